sonar_scheduler: RTL and testbench

- Round-robin scheduler that shares one hcsr04 ranging engine between N_SENSORS ultrasonic sensors.
- Selects a sensor, raises measure, waits for the engine's result or a timeout, then reports the result tagged with the sensor id.
- Holds a mandatory quiet gap between measurements so echoes from one sensor cannot be taken as another sensor's echo.
- Sits between the fountain control logic and the hcsr04 instance. sel drives the external trigger demux and echo mux.

---
 rtl/sonar_pkg.sv | 13 +
 rtl/rr_pick.sv | 40 ++++
 rtl/sonar_scheduler.sv | 171 +++++++++++++++++
 tb/tb_sonar_scheduler.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// Shared types and constants for the multi-sensor sonar scheduler.
package sonar_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    GAP     = 2'd2
  } state_e;

  localparam int TICKS_W = 16;
  localparam logic [TICKS_W-1:0] TIMEOUT_CODE = 16'hFFFF;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set bit of mask at or after start,
// wrapping modulo N_SENSORS.
module rr_pick #(
  parameter  int N_SENSORS = 4,
  localparam int SEL_W     = $clog2(N_SENSORS)
) (
  input  logic [N_SENSORS-1:0] mask,
  input  logic [SEL_W-1:0]     start,
  output logic [SEL_W-1:0]     index,
  output logic                 found
);

  localparam logic [SEL_W:0] N_W = (SEL_W+1)'(N_SENSORS);

  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base,
                                                input logic [SEL_W:0]   off);
    logic [SEL_W:0] s;
    s = {1'b0, base} + off;
    return (s >= N_W) ? SEL_W'(s - N_W) : s[SEL_W-1:0];
  endfunction

  logic [SEL_W-1:0] cand_s;

  // Scan offsets 0..N-1 from start; the first enabled candidate wins.
  always_comb begin
    index  = '0;
    found  = 1'b0;
    cand_s = '0;
    for (int i = 0; i < N_SENSORS; i++) begin
      cand_s = wrap_add(start, (SEL_W+1)'(i));
      if (!found && mask[cand_s]) begin
        index = cand_s;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/sonar_scheduler.sv
// Round-robin scheduler sharing one hcsr04 ranging engine between several
// sensors, with a per-measurement timeout and a mandatory quiet gap.
module sonar_scheduler
  import sonar_pkg::*;
#(
  parameter  int N_SENSORS     = 4,
  parameter  int GAP_TICKS     = 6000,
  parameter  int TIMEOUT_TICKS = 4000,
  localparam int SEL_W         = $clog2(N_SENSORS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tclk,
  input  logic                 run,
  input  logic [N_SENSORS-1:0] sensor_en,
  output logic                 measure,
  output logic [SEL_W-1:0]     sel,
  input  logic [TICKS_W-1:0]   ticks,
  input  logic                 valid,
  output logic [TICKS_W-1:0]   result_ticks,
  output logic [SEL_W-1:0]     result_id,
  output logic                 result_valid,
  output logic                 result_timeout,
  output logic                 busy
);

  localparam logic [TICKS_W-1:0] GAP_LAST = TICKS_W'(GAP_TICKS - 1);
  localparam logic [TICKS_W-1:0] TO_LAST  = TICKS_W'(TIMEOUT_TICKS - 1);

  state_e             state_q, state_d;
  logic [TICKS_W-1:0] cnt_q, cnt_d;
  logic               tclk_q;
  logic               first_pick_q, first_pick_d;
  logic               measure_q, measure_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [TICKS_W-1:0] res_ticks_q, res_ticks_d;
  logic [SEL_W-1:0]   res_id_q, res_id_d;
  logic               res_valid_q, res_valid_d;
  logic               res_timeout_q, res_timeout_d;
  logic               busy_q, busy_d;

  logic               tick_e_s;
  logic [SEL_W-1:0]   start_s;
  logic [SEL_W-1:0]   pick_s;
  logic               found_s;

  assign tick_e_s = tclk & ~tclk_q;

  // The sensor just served is considered last on the next pick.
  always_comb begin
    start_s = '0;
    if (first_pick_q) begin
      start_s = '0;
    end else if (sel_q == SEL_W'(N_SENSORS - 1)) begin
      start_s = '0;
    end else begin
      start_s = sel_q + SEL_W'(1);
    end
  end

  rr_pick #(.N_SENSORS(N_SENSORS)) u_pick (
    .mask  (sensor_en),
    .start (start_s),
    .index (pick_s),
    .found (found_s)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    first_pick_d  = first_pick_q;
    measure_d     = measure_q;
    sel_d         = sel_q;
    res_ticks_d   = res_ticks_q;
    res_id_d      = res_id_q;
    res_valid_d   = 1'b0;
    res_timeout_d = res_timeout_q;
    case (state_q)
      IDLE: begin
        if (run && found_s) begin
          sel_d        = pick_s;
          measure_d    = 1'b1;
          cnt_d        = '0;
          first_pick_d = 1'b0;
          state_d      = MEASURE;
        end else begin
          measure_d = 1'b0;
        end
      end
      MEASURE: begin
        // A completion arriving on the timeout tick still counts as a result.
        if (valid) begin
          res_ticks_d   = ticks;
          res_id_d      = sel_q;
          res_timeout_d = 1'b0;
          res_valid_d   = 1'b1;
          measure_d     = 1'b0;
          cnt_d         = '0;
          state_d       = GAP;
        end else if (tick_e_s && (cnt_q == TO_LAST)) begin
          res_ticks_d   = TIMEOUT_CODE;
          res_id_d      = sel_q;
          res_timeout_d = 1'b1;
          res_valid_d   = 1'b1;
          measure_d     = 1'b0;
          cnt_d         = '0;
          state_d       = GAP;
        end else if (tick_e_s) begin
          cnt_d = cnt_q + TICKS_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      GAP: begin
        if (tick_e_s) begin
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + TICKS_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        measure_d = 1'b0;
        cnt_d     = '0;
        state_d   = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      tclk_q        <= 1'b0;
      first_pick_q  <= 1'b1;
      measure_q     <= 1'b0;
      sel_q         <= '0;
      res_ticks_q   <= '0;
      res_id_q      <= '0;
      res_valid_q   <= 1'b0;
      res_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tclk_q        <= tclk;
      first_pick_q  <= first_pick_d;
      measure_q     <= measure_d;
      sel_q         <= sel_d;
      res_ticks_q   <= res_ticks_d;
      res_id_q      <= res_id_d;
      res_valid_q   <= res_valid_d;
      res_timeout_q <= res_timeout_d;
      busy_q        <= busy_d;
    end
  end

  assign measure        = measure_q;
  assign sel            = sel_q;
  assign result_ticks   = res_ticks_q;
  assign result_id      = res_id_q;
  assign result_valid   = res_valid_q;
  assign result_timeout = res_timeout_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_sonar_scheduler.sv
// Self-checking bench: behavioural hcsr04 engine plus a timeline reference
// model of the scheduler, compared against the DUT every clock.
module tb_sonar_scheduler;

  localparam int N   = 4;
  localparam int GAP = 10;
  localparam int TMO = 50;

  logic        clk = 1'b0;
  logic        rst, tclk, run, valid;
  logic [3:0]  sensor_en;
  logic [15:0] ticks;
  logic        measure, result_valid, result_timeout, busy;
  logic [1:0]  sel, result_id;
  logic [15:0] result_ticks;

  always #5 clk = ~clk;

  sonar_scheduler #(.N_SENSORS(N), .GAP_TICKS(GAP), .TIMEOUT_TICKS(TMO)) dut (
    .clk(clk), .rst(rst), .tclk(tclk), .run(run), .sensor_en(sensor_en),
    .measure(measure), .sel(sel), .ticks(ticks), .valid(valid),
    .result_ticks(result_ticks), .result_id(result_id), .result_valid(result_valid),
    .result_timeout(result_timeout), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // tclk generator (one rising edge every 4 clk) and hcsr04 engine model
  int  tdiv = 0;
  bit  tick_next;
  int  eng_cnt = 0;
  bit  eng_done = 0;
  int  eng_delay = 20;
  bit  silent [4];
  bit  rand_mode = 0;

  always @(negedge clk) begin
    tdiv      = (tdiv + 1) % 4;
    tick_next = (tdiv == 0) && !tclk;
    tclk      = (tdiv < 2);
    valid     = 1'b0;
    if (measure !== 1'b1) begin
      eng_cnt  = 0;
      eng_done = 0;
      ticks    = 16'(100 + int'(sel));
      if (rand_mode) begin
        eng_delay = $urandom_range(1, 60);
        if ($urandom_range(0, 15) == 0) begin
          valid = 1'b1;
          ticks = 16'($urandom);
        end
      end
    end else if (!eng_done && tick_next) begin
      eng_cnt++;
      if (eng_cnt == eng_delay && !silent[sel]) begin
        valid    = 1'b1;
        eng_done = 1;
        ticks    = rand_mode ? 16'($urandom) : 16'(100 + int'(sel));
      end
    end
  end

  // Reference model: timeline of ticks since measure rise / fall
  bit          tclk_prev = 0;
  bit          c_tick;
  logic        c_rst, c_run, c_valid;
  logic [3:0]  c_en;
  logic [15:0] c_ticks;
  int          gtick = 0, rise_t = 0, fall_t = 0;
  bit          m_meas = 0, m_gap = 0, m_first = 1, m_rv = 0, m_rto = 0;
  int          m_sel = 0, m_rid = 0, st;
  bit          fnd;
  logic [15:0] m_rt = 16'd0;
  bit          prev_meas_obs = 0;
  int          q_id[$], q_tk[$], q_to[$], q_sel[$];

  always @(posedge clk) begin
    c_rst = rst; c_run = run; c_valid = valid; c_en = sensor_en; c_ticks = ticks;
    c_tick = tclk && !tclk_prev;
    if (c_tick) gtick++;
    m_rv = 0;
    if (c_rst) begin
      tclk_prev = 1'b0;
      m_meas = 0; m_gap = 0; m_first = 1; m_sel = 0;
      m_rt = 16'd0; m_rid = 0; m_rto = 0;
    end else begin
      tclk_prev = tclk;
      if (m_meas) begin
        if (c_valid || (c_tick && gtick - rise_t == TMO)) begin
          m_rt   = c_valid ? c_ticks : 16'hFFFF;
          m_rto  = !c_valid;
          m_rid  = m_sel;
          m_rv   = 1;
          m_meas = 0;
          m_gap  = 1;
          fall_t = gtick;
        end
      end else if (m_gap) begin
        if (c_tick && gtick - fall_t == GAP) m_gap = 0;
      end else if (c_run && c_en != 4'd0) begin
        st  = m_first ? 0 : (m_sel + 1) % N;
        fnd = 0;
        for (int k = 0; k < N; k++) begin
          if (!fnd && c_en[(st + k) % N]) begin
            m_sel = (st + k) % N;
            fnd   = 1;
          end
        end
        m_first = 0;
        m_meas  = 1;
        rise_t  = gtick;
      end
    end
    #1;
    chk("measure", measure, m_meas);
    chk("sel", sel, m_sel);
    chk("busy", busy, m_meas || m_gap);
    chk("result_valid", result_valid, m_rv);
    chk("result_ticks", result_ticks, m_rt);
    chk("result_id", result_id, m_rid);
    chk("result_timeout", result_timeout, m_rto);
    if (result_valid === 1'b1) begin
      q_id.push_back(int'(result_id));
      q_tk.push_back(int'(result_ticks));
      q_to.push_back(int'(result_timeout));
    end
    if (measure === 1'b1 && !prev_meas_obs) q_sel.push_back(int'(sel));
    prev_meas_obs = (measure === 1'b1);
  end

  task automatic wait_strobes(input int n, input string name);
    int b = 0;
    while (q_id.size() < n && b < 4000) begin @(negedge clk); b++; end
    chk({name, "_strobes"}, 32'(q_id.size() >= n), 32'd1);
  endtask

  task automatic wait_rises(input int n, input string name);
    int b = 0;
    while (q_sel.size() < n && b < 4000) begin @(negedge clk); b++; end
    chk({name, "_rises"}, 32'(q_sel.size() >= n), 32'd1);
  endtask

  task automatic chk_res(input string name, input int i, input int id, input int tk, input int to);
    chk({name, "_id"}, (q_id.size() > i) ? q_id[i] : -1, id);
    chk({name, "_ticks"}, (q_tk.size() > i) ? q_tk[i] : -1, tk);
    chk({name, "_timeout"}, (q_to.size() > i) ? q_to[i] : -1, to);
  endtask

  int exp_seq1 [5] = '{0, 1, 2, 3, 0};
  int exp_seq2 [4] = '{1, 3, 1, 3};
  int rb;

  initial begin
    rst = 1'b1; run = 1'b0; sensor_en = 4'd0; tclk = 1'b0; valid = 1'b0; ticks = 16'd0;
    repeat (3) @(negedge clk);
    chk("reset_measure", measure, 0);
    chk("reset_busy", busy, 0);
    chk("reset_sel", sel, 0);
    chk("reset_rticks", result_ticks, 0);

    // 1: all sensors enabled, normal round robin
    rst = 1'b0; run = 1'b1; sensor_en = 4'b1111;
    wait_strobes(5, "t1");
    for (int i = 0; i < 5; i++) chk_res("t1", i, exp_seq1[i], 100 + exp_seq1[i], 0);

    // 2: sparse enable mask
    sensor_en = 4'b1010; q_sel.delete();
    wait_rises(4, "t2");
    for (int i = 0; i < 4; i++) chk("t2_sel", (q_sel.size() > i) ? q_sel[i] : -1, exp_seq2[i]);

    // 3: sensor 2 never answers (sensor 3 is mid-measurement now)
    silent[2] = 1; sensor_en = 4'b1111; q_id.delete(); q_tk.delete(); q_to.delete();
    wait_strobes(5, "t3");
    chk_res("t3_first", 0, 3, 103, 0);
    chk_res("t3_s0", 1, 0, 100, 0);
    chk_res("t3_lost", 3, 2, 32'hFFFF, 1);
    chk_res("t3_next", 4, 3, 103, 0);

    // 4: completion on exactly the timeout tick
    silent[2] = 0; eng_delay = TMO; sensor_en = 4'b0100;
    q_id.delete(); q_tk.delete(); q_to.delete();
    wait_strobes(1, "t4");
    chk_res("t4", 0, 2, 102, 0);
    repeat (10) @(negedge clk);
    chk("t4_one_strobe", q_id.size(), 1);

    // 5: run dropped mid-measurement, then run with empty mask
    eng_delay = 20; sensor_en = 4'b1111; rb = q_sel.size();
    wait_rises(rb + 1, "t5");
    repeat (20) @(negedge clk);
    run = 1'b0; q_id.delete(); q_tk.delete(); q_to.delete();
    wait_strobes(1, "t5");
    chk_res("t5", 0, 3, 103, 0);
    for (int b = 0; b < 300 && busy !== 1'b0; b++) @(negedge clk);
    repeat (50) @(negedge clk);
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_measure", measure, 0);
    run = 1'b1; sensor_en = 4'd0; rb = q_sel.size();
    repeat (800) @(negedge clk);
    chk("t5_empty_rises", q_sel.size(), rb);
    chk("t5_empty_busy", busy, 0);

    // 6: reset while measuring sensor 2
    sensor_en = 4'b1111;
    for (int b = 0; b < 3000 && !(measure === 1'b1 && sel === 2'd2); b++) @(negedge clk);
    chk("t6_reached_s2", sel, 2);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_measure", measure, 0);
    chk("t6_sel", sel, 0);
    chk("t6_rticks", result_ticks, 0);
    chk("t6_rid", result_id, 0);
    chk("t6_rtimeout", result_timeout, 0);
    chk("t6_busy", busy, 0);
    rst = 1'b0; q_id.delete(); q_tk.delete(); q_to.delete();
    wait_strobes(1, "t6");
    chk("t6_first_id", (q_id.size() > 0) ? q_id[0] : -1, 0);

    // Randomised traffic against the reference model
    rand_mode = 1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 1499) == 0) rst = 1'b1;
      if ($urandom_range(0, 149) == 0) run = ~run;
      if ($urandom_range(0, 79) == 0) sensor_en = 4'($urandom);
      if ($urandom_range(0, 199) == 0) silent[$urandom_range(0, 3)] = 1'($urandom);
    end
    rand_mode = 0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
